// File: rtl/dmem_bus_ctrl_if.sv
// ============================================================================
// Module      : dmem_bus_ctrl_if
// Description : Core dmem port plus slave-side request bus of the data-memory
//               bus controller. master = controller view, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_bus_ctrl_if #(
    parameter int NUM_SLAVES = 3
);
    logic                      dmem_enable;
    logic [31:0]               dmem_address;
    logic                      dmem_write_enable;
    logic [2:0]                dmem_mode;
    logic [31:0]               dmem_write_data;
    logic [31:0]               dmem_read_data;
    logic                      dmem_wait;
    logic                      dmem_error;
    logic [NUM_SLAVES-1:0]     slv_req;
    logic                      slv_we;
    logic [31:0]               slv_addr;
    logic [31:0]               slv_wdata;
    logic [3:0]                slv_byteen;
    logic [NUM_SLAVES*32-1:0]  slv_rdata;
    logic [NUM_SLAVES-1:0]     slv_ack;

    modport master (
        input  dmem_enable, dmem_address, dmem_write_enable, dmem_mode,
               dmem_write_data, slv_rdata, slv_ack,
        output dmem_read_data, dmem_wait, dmem_error, slv_req, slv_we,
               slv_addr, slv_wdata, slv_byteen
    );

    modport slave (
        output dmem_enable, dmem_address, dmem_write_enable, dmem_mode,
               dmem_write_data, slv_rdata, slv_ack,
        input  dmem_read_data, dmem_wait, dmem_error, slv_req, slv_we,
               slv_addr, slv_wdata, slv_byteen
    );
endinterface

`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
// ============================================================================
// Module      : dmem_bus_ctrl
// Description : Data-memory bus controller: region decode, store lane
//               formatting, load extraction, req/ack with timeout, faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bus_ctrl #(
    parameter int NUM_SLAVES   = 3,
    parameter int REGION_SHIFT = 16,
    parameter logic [NUM_SLAVES*(32-REGION_SHIFT)-1:0] REGION_TAGS =
        {16'h8000, 16'h7000, 16'h0000},
    parameter int TIMEOUT      = 255
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    dmem_bus_ctrl_if.master bus
);

    localparam int          c_TAG_W    = 32 - REGION_SHIFT;
    localparam int          c_SEL_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_SEL_W-1:0]    r_sel;
    logic [NUM_SLAVES-1:0] r_req;
    logic                  r_we;
    logic [2:0]            r_mode;
    logic [1:0]            r_lo;
    logic [31:0]           r_cnt;
    logic                  r_slv_we;
    logic [31:0]           r_slv_addr;
    logic [31:0]           r_slv_wdata;
    logic [3:0]            r_slv_byteen;
    logic [31:0]           r_rdata;
    logic                  r_error;

    logic                  w_hit;
    logic [c_SEL_W-1:0]    w_hit_idx;
    logic [NUM_SLAVES-1:0] w_req_oh;
    logic                  w_illegal;
    logic                  w_misal;
    logic                  w_fault;
    logic [31:0]           w_wdata;
    logic [3:0]            w_byteen;
    logic                  w_ack;
    logic [31:0]           w_rd;
    logic [31:0]           w_lane;
    logic [31:0]           w_load;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_req_oh  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (bus.dmem_address[31:REGION_SHIFT] == REGION_TAGS[i*c_TAG_W +: c_TAG_W]) begin
                w_hit     = 1'b1;
                w_hit_idx = c_SEL_W'(i);
                w_req_oh  = NUM_SLAVES'(1) << i;
            end
        end
    end

    always_comb begin
        w_illegal = (bus.dmem_mode == 3'd3) || (bus.dmem_mode == 3'd6) ||
                    (bus.dmem_mode == 3'd7) || (bus.dmem_write_enable && bus.dmem_mode[2]);
        w_misal   = ((bus.dmem_mode[1:0] == 2'd1) && bus.dmem_address[0]) ||
                    ((bus.dmem_mode[1:0] == 2'd2) && (bus.dmem_address[1:0] != 2'd0));
        w_fault   = w_illegal || w_misal || !w_hit;
    end

    always_comb begin
        w_wdata  = '0;
        w_byteen = 4'b1111;
        if (bus.dmem_write_enable) begin
            case (bus.dmem_mode[1:0])
                2'd0: begin
                    w_byteen = 4'b0001 << bus.dmem_address[1:0];
                    w_wdata  = {24'd0, bus.dmem_write_data[7:0]} << {bus.dmem_address[1:0], 3'b000};
                end
                2'd1: begin
                    w_byteen = bus.dmem_address[1] ? 4'b1100 : 4'b0011;
                    w_wdata  = bus.dmem_address[1] ? {bus.dmem_write_data[15:0], 16'd0}
                                                   : {16'd0, bus.dmem_write_data[15:0]};
                end
                default: w_wdata = bus.dmem_write_data;
            endcase
        end
    end

    // Only the selected slave's ack and read data are ever looked at.
    always_comb begin
        w_ack = 1'b0;
        w_rd  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel == c_SEL_W'(i)) begin
                w_ack = bus.slv_ack[i];
                w_rd  = bus.slv_rdata[i*32 +: 32];
            end
        end
        w_lane = w_rd >> {r_lo, 3'b000};
        case (r_mode)
            3'd0:    w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'd1:    w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'd4:    w_load = {24'd0, w_lane[7:0]};
            3'd5:    w_load = {16'd0, w_lane[15:0]};
            default: w_load = w_rd;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_req        <= '0;
            r_we         <= 1'b0;
            r_mode       <= 3'd0;
            r_lo         <= 2'd0;
            r_cnt        <= '0;
            r_slv_we     <= 1'b0;
            r_slv_addr   <= '0;
            r_slv_wdata  <= '0;
            r_slv_byteen <= '0;
            r_rdata      <= '0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.dmem_enable) begin
                        r_we   <= bus.dmem_write_enable;
                        r_mode <= bus.dmem_mode;
                        r_lo   <= bus.dmem_address[1:0];
                        r_cnt  <= '0;
                        if (w_fault) begin
                            r_state <= S_RESP;
                            r_error <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state      <= S_BUSY;
                            r_sel        <= w_hit_idx;
                            r_req        <= w_req_oh;
                            r_slv_we     <= bus.dmem_write_enable;
                            r_slv_addr   <= {bus.dmem_address[31:2], 2'b00};
                            r_slv_wdata  <= w_wdata;
                            r_slv_byteen <= w_byteen;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_ack || ((TIMEOUT != 0) && (r_cnt == c_TMO_LAST))) begin
                        r_state      <= S_RESP;
                        r_error      <= !w_ack;
                        r_rdata      <= (w_ack && !r_we) ? w_load : 32'd0;
                        r_req        <= '0;
                        r_slv_we     <= 1'b0;
                        r_slv_addr   <= '0;
                        r_slv_wdata  <= '0;
                        r_slv_byteen <= '0;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_error <= 1'b0;
                    r_rdata <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dmem_wait      = (r_state == S_IDLE) ? bus.dmem_enable : (r_state == S_BUSY);
    assign bus.dmem_read_data = r_rdata;
    assign bus.dmem_error     = r_error;
    assign bus.slv_req        = r_req;
    assign bus.slv_we         = r_slv_we;
    assign bus.slv_addr       = r_slv_addr;
    assign bus.slv_wdata      = r_slv_wdata;
    assign bus.slv_byteen     = r_slv_byteen;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
// ============================================================================
// Module      : tb_dmem_bus_ctrl
// Description : Scoreboard bench for dmem_bus_ctrl with directed accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_bus_ctrl;

    localparam int c_NS = 3;

    logic clk;
    logic reset_n;

    dmem_bus_ctrl_if #(.NUM_SLAVES(c_NS)) bus ();

    // Slave 0 = 0x8000, slave 1 = 0x7000, slave 2 = 0x0000.
    dmem_bus_ctrl #(
        .NUM_SLAVES  (c_NS),
        .REGION_SHIFT(16),
        .REGION_TAGS ({16'h0000, 16'h7000, 16'h8000}),
        .TIMEOUT     (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } resp_t;

    typedef struct {
        logic [2:0]  req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } stx_t;

    resp_t rq[$];
    stx_t  sq[$];
    int    total = 0;
    int    bad   = 0;

    int          ack_delay[c_NS];
    logic [31:0] srd[c_NS];
    logic [2:0]  stray;
    int          scnt[c_NS];

    assign bus.slv_rdata = {srd[2], srd[1], srd[0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model: ack after ack_delay request cycles (0 = never), plus stray acks.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < c_NS; i++) begin
            if (bus.slv_req[i]) scnt[i]++;
            else                scnt[i] = 0;
            bus.slv_ack[i] = (bus.slv_req[i] && ack_delay[i] != 0 && scnt[i] == ack_delay[i]) || stray[i];
        end
    end

    // Response monitor: a completed access is enable && !wait.
    always @(negedge clk) begin
        if (reset_n && bus.dmem_enable && !bus.dmem_wait) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                resp_t r;
                r = rq.pop_front();
                chk("read_data", bus.dmem_read_data, r.rd);
                chk("error", {31'd0, bus.dmem_error}, {31'd0, r.err});
            end
        end
    end

    // Slave-side monitor: bus fields stable during a request, zero otherwise.
    always @(negedge clk) begin
        if (bus.slv_req != 3'd0) begin
            if (sq.size() == 0) begin
                chk("unexpected_slv_req", {29'd0, bus.slv_req}, 32'd0);
            end else begin
                chk("slv_req", {29'd0, bus.slv_req}, {29'd0, sq[0].req});
                chk("slv_addr", bus.slv_addr, sq[0].addr);
                chk("slv_we", {31'd0, bus.slv_we}, {31'd0, sq[0].we});
                chk("slv_wdata", bus.slv_wdata, sq[0].wdata);
                chk("slv_byteen", {28'd0, bus.slv_byteen}, {28'd0, sq[0].be});
            end
        end else begin
            chk("slv_idle_zero", {31'd0, bus.slv_we} | bus.slv_addr | bus.slv_wdata | {28'd0, bus.slv_byteen}, 32'd0);
        end
    end

    task automatic do_access(input logic [31:0] a, input logic we, input logic [2:0] m,
                             input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                             input int ebusy, input logic [2:0] ereq, input logic [3:0] ebe,
                             input logic [31:0] ewd);
        resp_t r;
        stx_t  s;
        int    lat;
        int    busy;
        r.rd  = erd;
        r.err = eerr;
        rq.push_back(r);
        if (ebusy > 0) begin
            s.req   = ereq;
            s.addr  = {a[31:2], 2'b00};
            s.we    = we;
            s.wdata = ewd;
            s.be    = ebe;
            sq.push_back(s);
        end
        @(posedge clk);
        #1;
        bus.dmem_enable       = 1'b1;
        bus.dmem_address      = a;
        bus.dmem_write_enable = we;
        bus.dmem_mode         = m;
        bus.dmem_write_data   = wd;
        lat  = 0;
        busy = 0;
        forever begin
            @(negedge clk);
            if (bus.slv_req != 3'd0) busy++;
            if (!bus.dmem_wait) break;
            lat++;
            if (lat > 40) begin
                chk("wait_timeout", 32'd1, 32'd0);
                break;
            end
        end
        chk("wait_cycles", 32'(lat), 32'(ebusy + 1));
        chk("req_cycles", 32'(busy), 32'(ebusy));
        if (ebusy > 0 && sq.size() > 0) s = sq.pop_front();
        @(posedge clk);
        #1;
        bus.dmem_enable = 1'b0;
    endtask

    initial begin
        resp_t rtmp;
        reset_n               = 1'b0;
        bus.dmem_enable       = 1'b0;
        bus.dmem_address      = '0;
        bus.dmem_write_enable = 1'b0;
        bus.dmem_mode         = 3'd0;
        bus.dmem_write_data   = '0;
        bus.slv_ack           = '0;
        stray                 = '0;
        for (int i = 0; i < c_NS; i++) begin
            ack_delay[i] = 1;
            srd[i]       = '0;
            scnt[i]      = 0;
        end
        #12;
        chk("rst_wait", {31'd0, bus.dmem_wait}, 32'd0);
        chk("rst_req", {29'd0, bus.slv_req}, 32'd0);
        chk("rst_rdata", bus.dmem_read_data, 32'd0);
        chk("rst_error", {31'd0, bus.dmem_error}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // LW with ack in the 3rd BUSY cycle
        ack_delay[0] = 3; srd[0] = 32'hDEADBEEF;
        do_access(32'h8000_0004, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 3, 3'b001, 4'b1111, 32'h0);

        // Stores to slave 1, same-cycle ack; rdata must not leak into read_data
        ack_delay[1] = 1; srd[1] = 32'hFFFF_FFFF;
        do_access(32'h7000_0003, 1'b1, 3'd0, 32'h0000_00A5, 32'h0, 1'b0, 1, 3'b010, 4'b1000, 32'hA500_0000);
        do_access(32'h7000_0002, 1'b1, 3'd1, 32'h0000_1234, 32'h0, 1'b0, 1, 3'b010, 4'b1100, 32'h1234_0000);
        do_access(32'h7000_0001, 1'b1, 3'd0, 32'hFFFF_FF5A, 32'h0, 1'b0, 1, 3'b010, 4'b0010, 32'h0000_5A00);
        do_access(32'h7000_0000, 1'b1, 3'd1, 32'hABCD_8765, 32'h0, 1'b0, 1, 3'b010, 4'b0011, 32'h0000_8765);
        do_access(32'h7000_0008, 1'b1, 3'd2, 32'h1122_3344, 32'h0, 1'b0, 1, 3'b010, 4'b1111, 32'h1122_3344);

        // Load formatting from 0x80F07F81
        ack_delay[0] = 1; srd[0] = 32'h80F0_7F81;
        do_access(32'h8000_0000, 1'b0, 3'd0, 32'h0, 32'hFFFF_FF81, 1'b0, 1, 3'b001, 4'b1111, 32'h0);
        do_access(32'h8000_0000, 1'b0, 3'd4, 32'h0, 32'h0000_0081, 1'b0, 1, 3'b001, 4'b1111, 32'h0);
        do_access(32'h8000_0002, 1'b0, 3'd1, 32'h0, 32'hFFFF_80F0, 1'b0, 1, 3'b001, 4'b1111, 32'h0);
        do_access(32'h8000_0002, 1'b0, 3'd5, 32'h0, 32'h0000_80F0, 1'b0, 1, 3'b001, 4'b1111, 32'h0);
        do_access(32'h8000_0001, 1'b0, 3'd0, 32'h0, 32'h0000_007F, 1'b0, 1, 3'b001, 4'b1111, 32'h0);
        do_access(32'h8000_0003, 1'b0, 3'd0, 32'h0, 32'hFFFF_FF80, 1'b0, 1, 3'b001, 4'b1111, 32'h0);
        do_access(32'h8000_0000, 1'b0, 3'd1, 32'h0, 32'h0000_7F81, 1'b0, 1, 3'b001, 4'b1111, 32'h0);
        do_access(32'h8000_0002, 1'b0, 3'd4, 32'h0, 32'h0000_00F0, 1'b0, 1, 3'b001, 4'b1111, 32'h0);
        ack_delay[2] = 2; srd[2] = 32'h0BAD_F00D;
        do_access(32'h0000_0010, 1'b0, 3'd2, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 3'b100, 4'b1111, 32'h0);

        // Faults: RESP at T+1, no slave request
        do_access(32'h8000_0002, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 0, 3'b000, 4'b0000, 32'h0);
        do_access(32'h8000_0001, 1'b0, 3'd1, 32'h0, 32'h0, 1'b1, 0, 3'b000, 4'b0000, 32'h0);
        do_access(32'h8000_0000, 1'b0, 3'd3, 32'h0, 32'h0, 1'b1, 0, 3'b000, 4'b0000, 32'h0);
        do_access(32'h7000_0000, 1'b1, 3'd4, 32'h0, 32'h0, 1'b1, 0, 3'b000, 4'b0000, 32'h0);
        do_access(32'h1234_0000, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 0, 3'b000, 4'b0000, 32'h0);
        do_access(32'h8000_0000, 1'b0, 3'd7, 32'h0, 32'h0, 1'b1, 0, 3'b000, 4'b0000, 32'h0);

        // Timeout on slave 1 with a stray ack from slave 0
        ack_delay[1] = 0; stray = 3'b001;
        do_access(32'h7000_0000, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 4, 3'b010, 4'b1111, 32'h0);
        stray = 3'b000; ack_delay[1] = 1;

        // Async reset in the 2nd BUSY cycle
        ack_delay[0] = 3; srd[0] = 32'h1111_2222;
        begin
            stx_t s;
            s.req = 3'b001; s.addr = 32'h8000_0004; s.we = 1'b0; s.wdata = 32'h0; s.be = 4'b1111;
            sq.push_back(s);
        end
        @(posedge clk);
        #1;
        bus.dmem_enable = 1'b1; bus.dmem_address = 32'h8000_0004;
        bus.dmem_write_enable = 1'b0; bus.dmem_mode = 3'd2;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_reset_req", {29'd0, bus.slv_req}, 32'd1);
        reset_n = 1'b0;
        bus.dmem_enable = 1'b0;
        #1;
        chk("async_rst_req", {29'd0, bus.slv_req}, 32'd0);
        chk("async_rst_rdata", bus.dmem_read_data, 32'd0);
        chk("async_rst_error", {31'd0, bus.dmem_error}, 32'd0);
        chk("async_rst_wait", {31'd0, bus.dmem_wait}, 32'd0);
        sq.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        stray = 3'b001;
        repeat (2) @(negedge clk);
        chk("late_ack_wait", {31'd0, bus.dmem_wait}, 32'd0);
        chk("late_ack_error", {31'd0, bus.dmem_error}, 32'd0);
        stray = 3'b000;
        ack_delay[0] = 2; srd[0] = 32'hCAFE_F00D;
        do_access(32'h8000_0008, 1'b0, 3'd2, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 3'b001, 4'b1111, 32'h0);

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        while (rq.size() > 0) rtmp = rq.pop_front();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Parametrised data-memory bus controller that sits between the core's dmem port and NUM_SLAVES memory/MMIO slaves (ROM, RAM, MMIO, ...).
- Decodes the region from the upper address bits and builds byte enables and lane-shifted write data for SB/SH/SW.
- Formats load data for LB/LH/LW/LBU/LHU, including sign extension.
- Supports variable-latency slaves through a req/ack handshake, with a timeout, and reports misaligned, unmapped and illegal-mode accesses on dmem_error.

Parameters:
NUM_SLAVES, 3, number of slave ports (1..8).
REGION_SHIFT, 16, address bits [31:REGION_SHIFT] form the region tag.
REGION_TAGS, {16'h8000,16'h7000,16'h0000}, packed NUM_SLAVES x (32-REGION_SHIFT) tags; slave i uses slice i (slice 0 = LSBs).
TIMEOUT, 255, max BUSY cycles waiting for ack; 0 = no timeout.

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
dmem_enable  in  1  request valid; held stable by core until dmem_wait=0
dmem_address  in  32  byte address
dmem_write_enable  in  1  1=store, 0=load
dmem_mode  in  3  funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
dmem_write_data  in  32  store data, right-aligned
dmem_read_data  out  32  formatted load data, valid in RESP cycle
dmem_wait  out  1  stall to core
dmem_error  out  1  access fault, valid in RESP cycle
slv_req  out  NUM_SLAVES  one-hot request, held until ack
slv_we  out  1  write strobe (qualified by slv_req)
slv_addr  out  32  latched byte address, low 2 bits forced 0
slv_wdata  out  32  lane-shifted write data
slv_byteen  out  4  byte enables
slv_rdata  in  NUM_SLAVES*32  per-slave read data, slice i
slv_ack  in  NUM_SLAVES  per-slave completion

Behaviour:
- Reset (async, reset_n=0): state IDLE; slv_req=0 immediately; dmem_read_data=0; dmem_error=0; dmem_wait=0; timeout counter=0; latched request cleared.
- Reset mid-BUSY abandons the transaction; any late ack after reset is ignored.
- FSM states IDLE, BUSY, RESP.
- IDLE:
  - dmem_wait = dmem_enable (combinational).
  - On dmem_enable=1, latch address, we, mode and the formatted wdata/byteen.
  - Fault check, first match wins: (a) illegal mode (3,6,7, or a store with mode[2]=1); (b) misaligned (H with addr[0]=1, W with addr[1:0]!=0); (c) no tag matches.
  - Fault -> RESP with error=1 and no slave request. Otherwise -> BUSY with the selected index latched.
- BUSY:
  - dmem_wait=1; slv_req[sel]=1; counter increments each cycle.
  - slv_ack[sel]=1 -> capture the formatted slv_rdata slice, go to RESP, error=0.
  - Counter==TIMEOUT-1 without ack (TIMEOUT>0) -> RESP, error=1, read_data=0.
  - Acks from unselected slaves are ignored.
- RESP:
  - One cycle; dmem_wait=0; dmem_read_data and dmem_error registered and valid.
  - dmem_enable is ignored this cycle (it still carries the completed request).
  - Always -> IDLE. Minimum latency: accept T, BUSY T+1 with same-cycle ack, RESP T+2. Fault path: RESP at T+1.
- Decode:
  - Slave i matches when addr[31:REGION_SHIFT]==tag i.
  - On duplicate tags, the lowest index wins.
- Stores:
  - SB: byteen = 1<<addr[1:0], byte replicated to the selected lane, other lanes 0.
  - SH: byteen = addr[1] ? 4'b1100 : 4'b0011, halfword placed in the selected lane.
  - SW: byteen = 4'b1111.
  - Loads: byteen = 4'b1111, wdata = 0.
- Loads:
  - Select the lane from addr[1:0].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes the word through.
- On stores, dmem_read_data=0 in RESP.
- slv_addr, slv_we, slv_wdata and slv_byteen come from registers and are stable throughout BUSY; they are 0 outside BUSY.

Test Plan:
- LW 0x8000_0004 to slave 0, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> wait high 4 cycles, RESP read_data=0xDEADBEEF, error=0.
- SB 0x7000_0003, wdata=0x000000A5 -> slv_req=3'b010, byteen=4'b1000, wdata=0xA5000000, slv_we=1; then SH 0x7000_0002, wdata=0x1234 -> byteen=4'b1100, wdata=0x12340000.
- Slave rdata 0x80F0_7F81: LB addr[1:0]=0 -> 0xFFFFFF81; LBU -> 0x00000081; LH addr=..2 -> 0xFFFF80F0; LHU -> 0x000080F0.
- Faults: LW 0x8000_0002, LH 0x8000_0001, mode 3, SB with mode 4, LW 0x1234_0000 -> each gives RESP at T+1, error=1, slv_req never asserted.
- Timeout with TIMEOUT=4 and slave never acking -> slv_req high for 4 cycles, RESP error=1, read_data=0; a stray ack from another slave during BUSY is ignored.
- reset_n low in the 2nd BUSY cycle -> slv_req drops without waiting for clk, outputs 0; after release, a new LW completes normally.
